// File: rtl/adpll_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : adpll_pkg                                              |
// | Description : Shared ADPLL network types: scheduler state encoding,  |
// |               per-state loop gains and node coupling weight tables.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package adpll_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_TRACK   = 2'd2,
    ST_LOCKED  = 2'd3
  } state_e;

  // Loop gains per state; Kp is Q1.5 and Ki is Q1.8, so 32 is 1.0 and 0.125.
  localparam int c_kp_acquire = 32;
  localparam int c_ki_acquire = 32;
  localparam int c_kp_track   = 16;
  localparam int c_ki_track   = 8;
  localparam int c_kp_locked  = 8;
  localparam int c_ki_locked  = 2;

  // Node weights, each nibble {left, above, right, below}.
  localparam logic [15:0] c_w11_bi  = 16'h2011;
  localparam logic [15:0] c_w12_bi  = 16'h2002;
  localparam logic [15:0] c_w21_bi  = 16'h0220;
  localparam logic [15:0] c_w22_bi  = 16'h2200;
  localparam logic [15:0] c_w11_uni = 16'h4000;
  localparam logic [15:0] c_w12_uni = 16'h4000;
  localparam logic [15:0] c_w21_uni = 16'h0400;
  localparam logic [15:0] c_w22_uni = 16'h2200;

  // Packed node 11 / 12 / 21 / 22 from MSB to LSB.
  localparam logic [63:0] c_weights_bi  = {c_w11_bi, c_w12_bi, c_w21_bi, c_w22_bi};
  localparam logic [63:0] c_weights_uni = {c_w11_uni, c_w12_uni, c_w21_uni, c_w22_uni};

  function automatic int kp_for_state(input state_e s);
    int k;
    k = 0;
    case (s)
      ST_ACQUIRE: k = c_kp_acquire;
      ST_TRACK:   k = c_kp_track;
      ST_LOCKED:  k = c_kp_locked;
      default:    k = 0;
    endcase
    return k;
  endfunction

  function automatic int ki_for_state(input state_e s);
    int k;
    k = 0;
    case (s)
      ST_ACQUIRE: k = c_ki_acquire;
      ST_TRACK:   k = c_ki_track;
      ST_LOCKED:  k = c_ki_locked;
      default:    k = 0;
    endcase
    return k;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lock_detector.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : lock_detector                                          |
// | Description : Saturating |error| and in-limit / out-of-limit run     |
// |               counters; pulses lock_hit / loss_hit on the tick that  |
// |               completes a run.                                       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module lock_detector #(
  parameter int PDET_WIDTH    = 8,
  parameter int LOCK_THRESH   = 4,
  parameter int LOCK_COUNT    = 32,
  parameter int UNLOCK_THRESH = 16,
  parameter int LOSS_COUNT    = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_tick,
  input  logic                         i_clear,
  input  logic signed [PDET_WIDTH-1:0] i_error,
  output logic                         o_lock_hit,
  output logic                         o_loss_hit
);

  localparam int c_in_w  = $clog2(LOCK_COUNT + 1);
  localparam int c_out_w = $clog2(LOSS_COUNT + 1);

  localparam logic [PDET_WIDTH-2:0] c_lock_thr   = (PDET_WIDTH-1)'(LOCK_THRESH);
  localparam logic [PDET_WIDTH-2:0] c_unlock_thr = (PDET_WIDTH-1)'(UNLOCK_THRESH);
  localparam logic [c_in_w-1:0]     c_in_max     = c_in_w'(LOCK_COUNT);
  localparam logic [c_in_w-1:0]     c_in_last    = c_in_w'(LOCK_COUNT - 1);
  localparam logic [c_out_w-1:0]    c_out_max    = c_out_w'(LOSS_COUNT);
  localparam logic [c_out_w-1:0]    c_out_last   = c_out_w'(LOSS_COUNT - 1);
  localparam logic signed [PDET_WIDTH-1:0] c_err_min = {1'b1, {(PDET_WIDTH-1){1'b0}}};

  logic signed [PDET_WIDTH-1:0] w_err_neg;
  logic [PDET_WIDTH-2:0]        w_err_mag;
  logic                         w_in_limit;
  logic                         w_out_limit;
  logic [c_in_w-1:0]            r_in_cnt;
  logic [c_out_w-1:0]           r_out_cnt;

  assign w_err_neg = -i_error;

  // Magnitude of the phase error; the most negative code saturates to full scale.
  always_comb begin
    w_err_mag = i_error[PDET_WIDTH-2:0];
    if (i_error == c_err_min) begin
      w_err_mag = '1;
    end else if (i_error[PDET_WIDTH-1]) begin
      w_err_mag = w_err_neg[PDET_WIDTH-2:0];
    end
  end

  assign w_in_limit  = (w_err_mag <= c_lock_thr);
  assign w_out_limit = (w_err_mag >  c_unlock_thr);

  // Consecutive-tick run counters; a state change in the scheduler restarts both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
    end else if (i_clear) begin
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
    end else if (i_tick) begin
      if (!w_in_limit)             r_in_cnt <= '0;
      else if (r_in_cnt != c_in_max) r_in_cnt <= r_in_cnt + 1'b1;
      if (!w_out_limit)              r_out_cnt <= '0;
      else if (r_out_cnt != c_out_max) r_out_cnt <= r_out_cnt + 1'b1;
    end
  end

  // Hits fire on the tick that brings a run to its target length.
  assign o_lock_hit = i_tick && w_in_limit  && (r_in_cnt  == c_in_last);
  assign o_loss_hit = i_tick && w_out_limit && (r_out_cnt == c_out_last);

endmodule
`default_nettype wire

// File: rtl/network_gain_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : network_gain_scheduler                                 |
// | Description : Sequences the ADPLL network IDLE -> ACQUIRE -> TRACK   |
// |               -> LOCKED, drives loop gains, enable, lock flag and    |
// |               the topology-dependent node coupling weights.          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
import adpll_pkg::*;

module network_gain_scheduler #(
  parameter int PDET_WIDTH    = 8,
  parameter int KP_WIDTH      = 6,
  parameter int KI_WIDTH      = 9,
  parameter int ACQ_TICKS     = 64,
  parameter int TRK_TICKS     = 128,
  parameter int LOCK_THRESH   = 4,
  parameter int LOCK_COUNT    = 32,
  parameter int UNLOCK_THRESH = 16,
  parameter int LOSS_COUNT    = 8
) (
  input  logic                         fpga_clk_i,
  input  logic                         rst_n_i,
  input  logic                         enable_i,
  input  logic                         uni_dir_i,
  input  logic                         manual_i,
  input  logic [3:0]                   kp_manual_i,
  input  logic [3:0]                   ki_manual_i,
  input  logic                         ref_tick_i,
  input  logic signed [PDET_WIDTH-1:0] error_i,
  output logic                         enable_o,
  output logic [KP_WIDTH-1:0]          kp_o,
  output logic [KI_WIDTH-1:0]          ki_o,
  output logic [63:0]                  weights_o,
  output logic                         locked_o,
  output logic [1:0]                   state_o
);

  localparam int c_tick_max = (ACQ_TICKS > TRK_TICKS) ? ACQ_TICKS : TRK_TICKS;
  localparam int c_tick_w   = $clog2(c_tick_max + 1);
  localparam logic [c_tick_w-1:0] c_acq_last = c_tick_w'(ACQ_TICKS - 1);
  localparam logic [c_tick_w-1:0] c_trk_last = c_tick_w'(TRK_TICKS - 1);

  state_e                r_state;
  state_e                w_state_nxt;
  logic                  w_state_chg;
  logic [c_tick_w-1:0]   r_tick_cnt;
  logic                  r_uni_dir_q;
  logic                  w_topo_chg;
  logic                  w_acq_done;
  logic                  w_trk_timeout;
  logic                  w_lock_hit;
  logic                  w_loss_hit;
  logic [KP_WIDTH-1:0]   r_kp;
  logic [KI_WIDTH-1:0]   r_ki;
  logic [63:0]           r_weights;

  lock_detector #(
    .PDET_WIDTH    (PDET_WIDTH),
    .LOCK_THRESH   (LOCK_THRESH),
    .LOCK_COUNT    (LOCK_COUNT),
    .UNLOCK_THRESH (UNLOCK_THRESH),
    .LOSS_COUNT    (LOSS_COUNT)
  ) u_lock_detector (
    .clk        (fpga_clk_i),
    .rst_n      (rst_n_i),
    .i_tick     (ref_tick_i),
    .i_clear    (w_state_chg),
    .i_error    (error_i),
    .o_lock_hit (w_lock_hit),
    .o_loss_hit (w_loss_hit)
  );

  // Topology edge: live input compared against last clock's sample.
  assign w_topo_chg    = uni_dir_i ^ r_uni_dir_q;
  assign w_acq_done    = ref_tick_i && (r_tick_cnt == c_acq_last);
  assign w_trk_timeout = ref_tick_i && (r_tick_cnt == c_trk_last);

  // Next-state logic; disable wins everywhere, topology change beats lock/loss.
  always_comb begin
    w_state_nxt = r_state;
    if (!enable_i) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:    w_state_nxt = ST_ACQUIRE;
        ST_ACQUIRE: if (w_acq_done) w_state_nxt = ST_TRACK;
        ST_TRACK: begin
          if (w_topo_chg)         w_state_nxt = ST_ACQUIRE;
          else if (w_lock_hit)    w_state_nxt = ST_LOCKED;
          else if (w_trk_timeout) w_state_nxt = ST_ACQUIRE;
        end
        ST_LOCKED:  if (w_topo_chg || w_loss_hit) w_state_nxt = ST_ACQUIRE;
        default:    w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign w_state_chg = (w_state_nxt != r_state);

  // State register and topology sample.
  always_ff @(posedge fpga_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= ST_IDLE;
      r_uni_dir_q <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_uni_dir_q <= uni_dir_i;
    end
  end

  // Reference tick counter: restarts on every state change, saturates at full scale.
  always_ff @(posedge fpga_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_tick_cnt <= '0;
    end else if (w_state_chg) begin
      r_tick_cnt <= '0;
    end else if (ref_tick_i && (r_tick_cnt != '1)) begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  // Gains follow the registered state one clock later; manual override outside IDLE.
  always_ff @(posedge fpga_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_kp <= '0;
      r_ki <= '0;
    end else if (manual_i && (r_state != ST_IDLE)) begin
      r_kp <= KP_WIDTH'(kp_manual_i);
      r_ki <= KI_WIDTH'(ki_manual_i);
    end else begin
      r_kp <= KP_WIDTH'(kp_for_state(r_state));
      r_ki <= KI_WIDTH'(ki_for_state(r_state));
    end
  end

  // Coupling weights track the topology input with one clock of latency in any state.
  always_ff @(posedge fpga_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_weights <= '0;
    end else begin
      r_weights <= uni_dir_i ? c_weights_uni : c_weights_bi;
    end
  end

  assign kp_o      = r_kp;
  assign ki_o      = r_ki;
  assign weights_o = r_weights;
  assign enable_o  = (r_state != ST_IDLE);
  assign locked_o  = (r_state == ST_LOCKED);
  assign state_o   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_network_gain_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_network_gain_scheduler                              |
// | Description : Self-checking bench for network_gain_scheduler with an |
// |               expected-result queue popped after each DUT update.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_network_gain_scheduler;

  localparam logic [1:0]  S_IDLE   = 2'd0;
  localparam logic [1:0]  S_ACQ    = 2'd1;
  localparam logic [1:0]  S_TRK    = 2'd2;
  localparam logic [1:0]  S_LOCKED = 2'd3;
  localparam logic [63:0] c_w_bi   = 64'h2011_2002_0220_2200;
  localparam logic [63:0] c_w_uni  = 64'h4000_4000_0400_2200;

  logic              r_clk = 1'b0;
  logic              r_rst_n;
  logic              r_enable;
  logic              r_uni;
  logic              r_manual;
  logic [3:0]        r_kpm;
  logic [3:0]        r_kim;
  logic              r_tick;
  logic signed [7:0] r_err;
  logic              w_enable;
  logic [5:0]        w_kp;
  logic [8:0]        w_ki;
  logic [63:0]       w_weights;
  logic              w_locked;
  logic [1:0]        w_state;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string      tag;
    logic [1:0] st;
    logic [5:0] kp;
    logic [8:0] ki;
  } exp_t;

  exp_t r_sb[$];

  network_gain_scheduler dut (
    .fpga_clk_i  (r_clk),
    .rst_n_i     (r_rst_n),
    .enable_i    (r_enable),
    .uni_dir_i   (r_uni),
    .manual_i    (r_manual),
    .kp_manual_i (r_kpm),
    .ki_manual_i (r_kim),
    .ref_tick_i  (r_tick),
    .error_i     (r_err),
    .enable_o    (w_enable),
    .kp_o        (w_kp),
    .ki_o        (w_ki),
    .weights_o   (w_weights),
    .locked_o    (w_locked),
    .state_o     (w_state)
  );

  always #5 r_clk = ~r_clk;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [1:0] st, input int kp, input int ki);
    exp_t e;
    e.tag = tag;
    e.st  = st;
    e.kp  = 6'(kp);
    e.ki  = 9'(ki);
    r_sb.push_back(e);
  endtask

  // Pop one expectation and compare every status output against it.
  task automatic sb_check();
    exp_t e;
    check_val("sb_depth", 64'(r_sb.size()), 64'd1);
    if (r_sb.size() > 0) begin
      e = r_sb.pop_front();
      check_val({e.tag, "_state"},  64'(w_state),  64'(e.st));
      check_val({e.tag, "_kp"},     64'(w_kp),     64'(e.kp));
      check_val({e.tag, "_ki"},     64'(w_ki),     64'(e.ki));
      check_val({e.tag, "_enable"}, 64'(w_enable), 64'(e.st != S_IDLE));
      check_val({e.tag, "_locked"}, 64'(w_locked), 64'(e.st == S_LOCKED));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge r_clk);
  endtask

  // One-cycle reference tick; returns at the falling edge after it was sampled.
  task automatic pulse_tick(input int err);
    r_err  = 8'(err);
    r_tick = 1'b1;
    @(negedge r_clk);
    r_tick = 1'b0;
  endtask

  task automatic tick_n(input int err, input int n);
    repeat (n) begin
      pulse_tick(err);
      idle(7);
    end
  endtask

  task automatic acq_to_trk(input string tag, input int err, input int kpa, input int kia,
                            input int kpt, input int kit);
    tick_n(err, 63);
    sb_push({tag, "_acq63"}, S_ACQ, kpa, kia);
    sb_check();
    sb_push({tag, "_trk_edge"}, S_TRK, kpa, kia);
    pulse_tick(err);
    sb_check();
    sb_push({tag, "_trk_gain"}, S_TRK, kpt, kit);
    idle(1);
    sb_check();
    idle(6);
  endtask

  task automatic trk_to_lock(input string tag, input int kpt, input int kit,
                             input int kpl, input int kil);
    tick_n(0, 31);
    sb_push({tag, "_trk31"}, S_TRK, kpt, kit);
    sb_check();
    sb_push({tag, "_lock_edge"}, S_LOCKED, kpt, kit);
    pulse_tick(0);
    sb_check();
    sb_push({tag, "_lock_gain"}, S_LOCKED, kpl, kil);
    idle(1);
    sb_check();
    idle(6);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    r_rst_n  = 1'b0;
    r_enable = 1'b0;
    r_uni    = 1'b0;
    r_manual = 1'b0;
    r_kpm    = 4'd0;
    r_kim    = 4'd0;
    r_tick   = 1'b0;
    r_err    = 8'sd0;
    idle(3);
    sb_push("rst", S_IDLE, 0, 0);
    sb_check();
    check_val("rst_weights", w_weights, 64'd0);

    // First clock after release loads the bi-directional table.
    r_rst_n = 1'b1;
    idle(1);
    check_val("w_bi_after_rst", w_weights, c_w_bi);
    sb_push("post_rst", S_IDLE, 0, 0);
    sb_check();

    r_enable = 1'b1;
    idle(1);
    sb_push("en_acq", S_ACQ, 0, 0);
    sb_check();
    idle(1);
    sb_push("acq_gain", S_ACQ, 32, 32);
    sb_check();

    // Nominal acquisition and lock with zero error.
    acq_to_trk("p1", 0, 32, 32, 16, 8);
    trk_to_lock("p1", 16, 8, 8, 2);

    // Loss hysteresis: seven bad ticks then a good one keeps lock.
    tick_n(20, 7);
    tick_n(0, 1);
    sb_push("loss7", S_LOCKED, 8, 2);
    sb_check();
    tick_n(-20, 7);
    sb_push("loss_pre", S_LOCKED, 8, 2);
    sb_check();
    sb_push("loss_edge", S_ACQ, 8, 2);
    pulse_tick(-20);
    sb_check();
    sb_push("loss_gain", S_ACQ, 32, 32);
    idle(1);
    sb_check();
    idle(6);

    // Most negative error saturates and never locks; TRACK times out.
    acq_to_trk("p2", -128, 32, 32, 16, 8);
    r_err = -8'sd128;
    #1;
    check_val("mag_sat", 64'(dut.u_lock_detector.w_err_mag), 64'd127);
    tick_n(-128, 127);
    sb_push("trk127", S_TRK, 16, 8);
    sb_check();
    sb_push("trk_timeout", S_ACQ, 16, 8);
    pulse_tick(-128);
    sb_check();
    sb_push("timeout_gain", S_ACQ, 32, 32);
    idle(1);
    sb_check();
    idle(6);

    // Topology change coinciding with loss of lock.
    acq_to_trk("p3", 0, 32, 32, 16, 8);
    trk_to_lock("p3", 16, 8, 8, 2);
    tick_n(-20, 7);
    r_uni = 1'b1;
    #1;
    check_val("w_latency", w_weights, c_w_bi);
    sb_push("topo_loss", S_ACQ, 8, 2);
    pulse_tick(-20);
    sb_check();
    check_val("w_uni", w_weights, c_w_uni);
    sb_push("topo_loss_gain", S_ACQ, 32, 32);
    idle(1);
    sb_check();
    idle(6);

    // Topology change alone in TRACK.
    acq_to_trk("p4", 0, 32, 32, 16, 8);
    r_uni = 1'b0;
    idle(1);
    sb_push("topo_trk", S_ACQ, 16, 8);
    sb_check();
    check_val("w_back_bi", w_weights, c_w_bi);
    idle(1);
    sb_push("topo_trk_gain", S_ACQ, 32, 32);
    sb_check();

    // Manual gains through every active state, then disable.
    r_manual = 1'b1;
    r_kpm    = 4'd5;
    r_kim    = 4'd3;
    idle(1);
    sb_push("man_acq", S_ACQ, 5, 3);
    sb_check();
    acq_to_trk("p5", 0, 5, 3, 5, 3);
    trk_to_lock("p5", 5, 3, 5, 3);
    r_enable = 1'b0;
    idle(1);
    sb_push("dis_idle", S_IDLE, 5, 3);
    sb_check();
    idle(1);
    sb_push("dis_gain", S_IDLE, 0, 0);
    sb_check();
    r_manual = 1'b0;

    // Asynchronous reset in the middle of TRACK.
    r_enable = 1'b1;
    idle(1);
    sb_push("re_en", S_ACQ, 0, 0);
    sb_check();
    acq_to_trk("p6", 0, 32, 32, 16, 8);
    tick_n(0, 3);
    @(posedge r_clk);
    #2;
    r_rst_n = 1'b0;
    #1;
    sb_push("arst", S_IDLE, 0, 0);
    sb_check();
    check_val("arst_weights", w_weights, 64'd0);
    @(negedge r_clk);
    r_rst_n = 1'b1;
    idle(1);
    sb_push("arst_release", S_ACQ, 0, 0);
    sb_check();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
